// File: rtl/config_link_pkg.sv
// Shared definitions for the host-link configuration writer: frame parser
// states and the config-memory word/address widths used by the CPU top level.
package config_link_pkg;

    localparam int          CFG_DATA_W   = 32;
    localparam int          CFG_ADDR_W   = 8;
    localparam logic [7:0]  SYNC_DEFAULT = 8'hA5;

    typedef enum logic [2:0] {
        IDLE,
        HDR_ADDR,
        HDR_COUNT,
        DATA,
        CHK
    } cfw_state_e;

endpackage

// File: rtl/config_frame_writer_if.sv
// Byte-stream input, config-memory write port and frame status of the writer.
// master = host side (drives the stream), slave = the frame writer.
interface config_frame_writer_if #(
    parameter int ERR_CNT_W = 8
);
    logic                                  in_valid;
    logic [7:0]                            in_data;
    logic                                  in_ready;
    logic [config_link_pkg::CFG_DATA_W-1:0] config_data;
    logic [config_link_pkg::CFG_ADDR_W-1:0] config_addr;
    logic                                  config_wren;
    logic                                  frame_ok;
    logic                                  frame_err;
    logic [ERR_CNT_W-1:0]                  err_count;
    logic                                  busy;

    modport master (
        output in_valid, in_data,
        input  in_ready, config_data, config_addr, config_wren,
               frame_ok, frame_err, err_count, busy
    );

    modport slave (
        input  in_valid, in_data,
        output in_ready, config_data, config_addr, config_wren,
               frame_ok, frame_err, err_count, busy
    );
endinterface

// File: rtl/frame_timeout_counter.sv
// Counts consecutive enabled cycles without an accepted byte; expire_o is a
// combinational flag in the TIMEOUT_CYCLES-th such cycle.
module frame_timeout_counter #(
    parameter int TIMEOUT_CYCLES = 65536
) (
    input  logic clk,
    input  logic reset_n,
    input  logic en_i,
    input  logic reload_i,
    output logic expire_o
);
    localparam int            CW    = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    assign expire_o = en_i && !reload_i && (cnt_q == LIMIT);

    always_comb begin
        cnt_d = cnt_q;
        if (!en_i || reload_i) begin
            cnt_d = '0;
        end else if (!expire_o) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: rtl/config_frame_writer.sv
// Parses SYNC/ADDR/COUNT/data/CHK frames from the host link and emits 32-bit
// config-memory writes with auto-incrementing address plus frame status.
module config_frame_writer
    import config_link_pkg::*;
#(
    parameter logic [7:0] SYNC_BYTE      = SYNC_DEFAULT,
    parameter int         TIMEOUT_CYCLES = 65536,
    parameter int         ERR_CNT_W      = 8
) (
    input  logic                   clk,
    input  logic                   reset_n,
    config_frame_writer_if.slave   bus
);
    cfw_state_e            state_q, state_d;
    logic [CFG_ADDR_W-1:0] ptr_q, ptr_d;
    logic [7:0]            words_q, words_d;
    logic [1:0]            idx_q, idx_d;
    logic [23:0]           asm_q, asm_d;
    logic [7:0]            chk_q, chk_d;
    logic [CFG_DATA_W-1:0] cdata_q, cdata_d;
    logic [CFG_ADDR_W-1:0] caddr_q, caddr_d;
    logic                  wren_q, wren_d;
    logic                  ok_q, ok_d;
    logic                  err_q, err_d;
    logic [ERR_CNT_W-1:0]  errc_q, errc_d;
    logic                  rdy_q;
    logic                  acc;
    logic                  expire;
    logic [7:0]            din;

    assign acc = bus.in_valid && rdy_q;
    assign din = bus.in_data;

    frame_timeout_counter #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_tmo (
        .clk      (clk),
        .reset_n  (reset_n),
        .en_i     (state_q != IDLE),
        .reload_i (acc),
        .expire_o (expire)
    );

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        words_d = words_q;
        idx_d   = idx_q;
        asm_d   = asm_q;
        chk_d   = chk_q;
        cdata_d = cdata_q;
        caddr_d = caddr_q;
        wren_d  = 1'b0;
        ok_d    = 1'b0;
        err_d   = 1'b0;
        errc_d  = errc_q;

        case (state_q)
            IDLE: begin
                if (acc && din == SYNC_BYTE) state_d = HDR_ADDR;
            end
            HDR_ADDR: begin
                if (acc) begin
                    ptr_d   = din;
                    chk_d   = din;
                    state_d = HDR_COUNT;
                end
            end
            HDR_COUNT: begin
                if (acc) begin
                    words_d = din;
                    chk_d   = chk_q ^ din;
                    idx_d   = 2'd0;
                    state_d = (din == 8'd0) ? CHK : DATA;
                end
            end
            DATA: begin
                if (acc) begin
                    chk_d = chk_q ^ din;
                    asm_d = {asm_q[15:0], din};
                    idx_d = idx_q + 2'd1;
                    // Word complete: commit now, checksum only flags later.
                    if (idx_q == 2'd3) begin
                        wren_d  = 1'b1;
                        cdata_d = {asm_q, din};
                        caddr_d = ptr_q;
                        ptr_d   = ptr_q + 8'd1;
                        words_d = words_q - 8'd1;
                        if (words_q == 8'd1) state_d = CHK;
                    end
                end
            end
            CHK: begin
                if (acc) begin
                    ok_d    = (din == chk_q);
                    err_d   = (din != chk_q);
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Expiry only fires in a cycle with no accepted byte, so no write
        // or checksum result can collide with it.
        if (expire) begin
            state_d = IDLE;
            err_d   = 1'b1;
        end

        if (err_d && errc_q != '1) errc_d = errc_q + ERR_CNT_W'(1);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            words_q <= '0;
            idx_q   <= '0;
            asm_q   <= '0;
            chk_q   <= '0;
            cdata_q <= '0;
            caddr_q <= '0;
            wren_q  <= 1'b0;
            ok_q    <= 1'b0;
            err_q   <= 1'b0;
            errc_q  <= '0;
            rdy_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            words_q <= words_d;
            idx_q   <= idx_d;
            asm_q   <= asm_d;
            chk_q   <= chk_d;
            cdata_q <= cdata_d;
            caddr_q <= caddr_d;
            wren_q  <= wren_d;
            ok_q    <= ok_d;
            err_q   <= err_d;
            errc_q  <= errc_d;
            rdy_q   <= 1'b1;
        end
    end

    assign bus.in_ready    = rdy_q;
    assign bus.config_data = cdata_q;
    assign bus.config_addr = caddr_q;
    assign bus.config_wren = wren_q;
    assign bus.frame_ok    = ok_q;
    assign bus.frame_err   = err_q;
    assign bus.err_count   = errc_q;
    assign bus.busy        = (state_q != IDLE);
endmodule

// File: tb/tb_config_frame_writer.sv
// Directed frames for config_frame_writer; expected writes/pulses are queued
// by the stimulus and checked (including arrival cycle) by a negedge monitor.
module tb_config_frame_writer;
    localparam int TMO = 16;

    typedef struct {
        int          kind;   // 0 write, 1 frame_ok, 2 frame_err
        logic [7:0]  addr;
        logic [31:0] data;
        int          due;    // negedge index at which the event must be seen
    } exp_t;

    logic clk = 1'b0;
    logic reset_n;
    int   compared = 0;
    int   fails    = 0;
    int   ncyc     = 0;
    int   last_acc = 0;
    exp_t sb[$];

    config_frame_writer_if #(.ERR_CNT_W(8)) bus ();

    config_frame_writer #(
        .SYNC_BYTE      (8'hA5),
        .TIMEOUT_CYCLES (TMO),
        .ERR_CNT_W      (8)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic take(input int kind);
        exp_t e;
        if (sb.size() == 0) begin
            compared++;
            fails++;
            $display("FAIL unexpected_event: got kind %0d at cycle %0d expected none", kind, ncyc);
        end else begin
            e = sb.pop_front();
            chk("event_kind", kind, e.kind);
            chk("event_cycle", ncyc, e.due);
            if (kind == 0) begin
                chk("wr_addr", {24'h0, bus.config_addr}, {24'h0, e.addr});
                chk("wr_data", bus.config_data, e.data);
            end
        end
    endtask

    initial forever begin
        @(negedge clk);
        ncyc++;
        if (reset_n === 1'b1) begin
            if (bus.config_wren) take(0);
            if (bus.frame_ok)    take(1);
            if (bus.frame_err)   take(2);
        end
    end

    // Present one byte and hold it until the edge that accepts it.
    task automatic send(input logic [7:0] b);
        int  t;
        logic rdy;
        t = 0;
        bus.in_valid = 1'b1;
        bus.in_data  = b;
        do begin
            rdy = bus.in_ready;
            @(posedge clk);
            #1;
            t++;
        end while (!rdy && t < 50);
        if (!rdy) begin
            compared++;
            fails++;
            $display("FAIL accept_timeout: got in_ready 0 expected 1 for byte %h", b);
        end
        last_acc = ncyc;
    endtask

    task automatic idle(input int n);
        bus.in_valid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic exp_ev(input int kind, input logic [7:0] a, input logic [31:0] d, input int lat);
        exp_t e;
        e.kind = kind; e.addr = a; e.data = d; e.due = last_acc + lat;
        sb.push_back(e);
    endtask

    task automatic frame_fe(input logic [7:0] c, input bit good);
        logic [7:0] addrs [3];
        addrs[0] = 8'hFE; addrs[1] = 8'hFF; addrs[2] = 8'h00;
        send(8'hA5); send(8'hFE); send(8'h03);
        for (int w = 1; w <= 3; w++) begin
            send(8'h00); send(8'h00); send(8'h00); send(8'(w));
            exp_ev(0, addrs[w-1], 32'(w), 1);
        end
        send(c);
        exp_ev(good ? 1 : 2, 8'h0, 32'h0, 1);
    endtask

    task automatic frame_deadbeef();
        send(8'hA5); send(8'h10); send(8'h01);
        send(8'hDE); send(8'hAD); send(8'hBE); send(8'hEF);
        exp_ev(0, 8'h10, 32'hDEADBEEF, 1);
        send(8'h33);
        exp_ev(1, 8'h0, 32'h0, 1);
    endtask

    initial begin
        reset_n = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_wren",  {31'h0, bus.config_wren}, 32'h0);
        chk("rst_ok",    {31'h0, bus.frame_ok},    32'h0);
        chk("rst_err",   {31'h0, bus.frame_err},   32'h0);
        chk("rst_errc",  {24'h0, bus.err_count},   32'h0);
        chk("rst_busy",  {31'h0, bus.busy},        32'h0);
        chk("rst_data",  bus.config_data,          32'h0);
        chk("rst_addr",  {24'h0, bus.config_addr}, 32'h0);
        chk("rst_ready", {31'h0, bus.in_ready},    32'h0);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        chk("ready_after_rst", {31'h0, bus.in_ready}, 32'h1);

        // Single word frame, checksum 10^01^DE^AD^BE^EF = 33
        frame_deadbeef();
        idle(2);
        chk("hold_data", bus.config_data, 32'hDEADBEEF);

        // Address wrap FE,FF,00; good chk FD then back-to-back bad chk FC
        frame_fe(8'hFD, 1'b1);
        frame_fe(8'hFC, 1'b0);
        idle(2);
        chk("errc_after_bad", {24'h0, bus.err_count}, 32'h1);

        // Junk before sync, COUNT=0 frame
        send(8'h00); send(8'h37); send(8'hA5); send(8'h20); send(8'h00); send(8'h20);
        exp_ev(1, 8'h0, 32'h0, 1);
        idle(2);

        // Stall after two of four data bytes: err one cycle after 16th idle cycle
        send(8'hA5); send(8'h05); send(8'h01); send(8'hAA); send(8'hBB);
        exp_ev(2, 8'h0, 32'h0, TMO + 1);
        chk("busy_mid_frame", {31'h0, bus.busy}, 32'h1);
        idle(TMO + 4);
        chk("busy_after_tmo", {31'h0, bus.busy}, 32'h0);
        chk("errc_after_tmo", {24'h0, bus.err_count}, 32'h2);
        frame_deadbeef();
        idle(2);

        // Reset mid-frame, then a clean frame (chk 40^01^11^22^33^44 = 05)
        send(8'hA5); send(8'h40); send(8'h01); send(8'h11); send(8'h22);
        bus.in_valid = 1'b0;
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("busy_in_rst", {31'h0, bus.busy}, 32'h0);
        reset_n = 1'b1;
        send(8'hA5); send(8'h40); send(8'h01);
        send(8'h11); send(8'h22); send(8'h33); send(8'h44);
        exp_ev(0, 8'h40, 32'h11223344, 1);
        send(8'h05);
        exp_ev(1, 8'h0, 32'h0, 1);
        idle(2);
        chk("errc_after_rst", {24'h0, bus.err_count}, 32'h0);

        // 256 bad frames: counter saturates at FF
        for (int i = 0; i < 256; i++) begin
            send(8'hA5); send(8'h00); send(8'h00); send(8'h01);
            exp_ev(2, 8'h0, 32'h0, 1);
            if (i == 0)   chk("errc_first", {24'h0, bus.err_count}, 32'h1);
            if (i == 254) chk("errc_255",   {24'h0, bus.err_count}, 32'hFF);
        end
        idle(5);
        chk("errc_sat", {24'h0, bus.err_count}, 32'hFF);
        chk("scoreboard_drain", sb.size(), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, fails);
        $finish;
    end
endmodule
